axistream_egress_fifo: RTL and testbench



---
 rtl/axistream_egress_fifo.sv | 140 ++++++++++++++
 tb/tb_axistream_egress_fifo.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axistream_egress_fifo.sv
// Store-and-forward AXI Stream packet FIFO: a packet is released to egress only once its TLAST word
// is stored; packets longer than the buffer are consumed and discarded whole.
module axistream_egress_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [63:0]          s_TDATA,
    input  logic                 s_TVALID,
    input  logic                 s_TLAST,
    output logic                 s_TREADY,
    output logic [63:0]          m_TDATA,
    output logic                 m_TVALID,
    output logic                 m_TLAST,
    input  logic                 m_TREADY,
    output logic                 drop_pulse,
    output logic [CNT_WIDTH-1:0] drop_count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2 + 1;

    typedef enum logic [0:0] {StStore, StDrop} state_e;

    logic [64:0]          mem_q [DEPTH];
    logic [64:0]          rd_word;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]        pkt_words_q, pkt_words_d;
    state_e               state_q, state_d;
    logic [63:0]          m_tdata_q, m_tdata_d;
    logic                 m_tlast_q, m_tlast_d;
    logic                 m_tvalid_q, m_tvalid_d;
    logic                 drop_pulse_q, drop_pulse_d;
    logic [CNT_WIDTH-1:0] drop_count_q, drop_count_d;
    logic                 full;
    logic                 s_hs;
    logic                 mem_we;
    logic                 load;

    // Full uses the pre-edge rd_ptr; a same-cycle egress load frees space only next cycle.
    assign full     = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
    assign s_TREADY = rst_n && ((state_q == StDrop) || !full);
    assign s_hs     = s_TVALID && s_TREADY;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        pkt_words_d  = pkt_words_q;
        mem_we       = 1'b0;
        drop_pulse_d = 1'b0;
        drop_count_d = drop_count_q;
        unique case (state_q)
            StStore: begin
                if (s_hs) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    if (s_TLAST) begin
                        commit_ptr_d = wr_ptr_q + PW'(1);
                        pkt_words_d  = '0;
                    end else if (pkt_words_q + PW'(1) == PW'(DEPTH)) begin
                        // Oversize packet: rewind the partial packet and swallow the rest.
                        state_d     = StDrop;
                        wr_ptr_d    = commit_ptr_q;
                        pkt_words_d = '0;
                    end else begin
                        pkt_words_d = pkt_words_q + PW'(1);
                    end
                end
            end
            StDrop: begin
                if (s_hs && s_TLAST) begin
                    drop_pulse_d = 1'b1;
                    if (drop_count_q != '1) begin
                        drop_count_d = drop_count_q + CNT_WIDTH'(1);
                    end
                    state_d = StStore;
                end
            end
        endcase
    end

    assign load    = (rd_ptr_q != commit_ptr_q) && (!m_tvalid_q || m_TREADY);
    assign rd_word = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        m_tdata_d  = m_tdata_q;
        m_tlast_d  = m_tlast_q;
        m_tvalid_d = m_tvalid_q && !m_TREADY;
        if (load) begin
            rd_ptr_d   = rd_ptr_q + PW'(1);
            m_tdata_d  = rd_word[63:0];
            m_tlast_d  = rd_word[64];
            m_tvalid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= {s_TLAST, s_TDATA};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StStore;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            pkt_words_q  <= '0;
            m_tdata_q    <= '0;
            m_tlast_q    <= 1'b0;
            m_tvalid_q   <= 1'b0;
            drop_pulse_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            pkt_words_q  <= pkt_words_d;
            m_tdata_q    <= m_tdata_d;
            m_tlast_q    <= m_tlast_d;
            m_tvalid_q   <= m_tvalid_d;
            drop_pulse_q <= drop_pulse_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign m_TDATA    = m_tdata_q;
    assign m_TLAST    = m_tlast_q;
    assign m_TVALID   = m_tvalid_q;
    assign drop_pulse = drop_pulse_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_axistream_egress_fifo.sv
// Randomised and directed bench for axistream_egress_fifo against a packet-level queue model.
module tb_axistream_egress_fifo;

    localparam int unsigned DEPTH_LOG2 = 4;
    localparam int unsigned CNT_WIDTH  = 16;
    localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;

    logic                 clk;
    logic                 rst_n;
    logic [63:0]          s_TDATA;
    logic                 s_TVALID;
    logic                 s_TLAST;
    logic                 s_TREADY;
    logic [63:0]          m_TDATA;
    logic                 m_TVALID;
    logic                 m_TLAST;
    logic                 m_TREADY;
    logic                 drop_pulse;
    logic [CNT_WIDTH-1:0] drop_count;

    axistream_egress_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_TDATA   (s_TDATA),
        .s_TVALID  (s_TVALID),
        .s_TLAST   (s_TLAST),
        .s_TREADY  (s_TREADY),
        .m_TDATA   (m_TDATA),
        .m_TVALID  (m_TVALID),
        .m_TLAST   (m_TLAST),
        .m_TREADY  (m_TREADY),
        .drop_pulse(drop_pulse),
        .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Packet-level model: words of the current packet collect in cur_q and move to exp_q on TLAST.
    logic [64:0] exp_q[$];
    logic [64:0] cur_q[$];
    bit          dropping;
    bit          pend_pulse;
    bit          prev_stall;
    logic [63:0] prev_data;
    logic        prev_last;
    int unsigned exp_cnt;
    int          egress_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            cur_q.delete();
            dropping   = 0;
            pend_pulse = 0;
            prev_stall = 0;
            exp_cnt    = 0;
        end else begin
            chk("drop_pulse", {63'd0, drop_pulse}, {63'd0, pend_pulse});
            chk("drop_count", {48'd0, drop_count}, 64'(exp_cnt));
            pend_pulse = 0;
            if (prev_stall) begin
                chk("stall_valid", {63'd0, m_TVALID}, 64'd1);
                chk("stall_data", m_TDATA, prev_data);
                chk("stall_last", {63'd0, m_TLAST}, {63'd0, prev_last});
            end
            if (exp_q.size() == 0) begin
                chk("no_uncommitted_valid", {63'd0, m_TVALID}, 64'd0);
            end else if (m_TVALID && m_TREADY) begin
                logic [64:0] w;
                w = exp_q.pop_front();
                chk("egress_data", m_TDATA, w[63:0]);
                chk("egress_last", {63'd0, m_TLAST}, {63'd0, w[64]});
                egress_cnt++;
            end
            prev_stall = m_TVALID && !m_TREADY;
            prev_data  = m_TDATA;
            prev_last  = m_TLAST;
            if (dropping) chk("drop_ready", {63'd0, s_TREADY}, 64'd1);
            if (s_TVALID && s_TREADY) begin
                if (dropping) begin
                    if (s_TLAST) begin
                        dropping   = 0;
                        pend_pulse = 1;
                        if (exp_cnt != (1 << CNT_WIDTH) - 1) exp_cnt++;
                    end
                end else begin
                    cur_q.push_back({s_TLAST, s_TDATA});
                    if (s_TLAST) begin
                        foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
                        cur_q.delete();
                    end else if (cur_q.size() == DEPTH) begin
                        dropping = 1;
                        cur_q.delete();
                    end
                end
            end
        end
    end

    task automatic send_word(input logic [63:0] d, input logic l);
        int t;
        logic hs;
        s_TVALID = 1'b1;
        s_TDATA  = d;
        s_TLAST  = l;
        t  = 0;
        hs = 1'b0;
        while (!hs && t < 200) begin
            @(negedge clk);
            hs = s_TREADY;
            @(posedge clk);
            #1;
            t++;
        end
        if (!hs) begin
            n_vec++;
            n_err++;
            $display("FAIL ingress_timeout: got no s_TREADY expected handshake at %0t", $time);
        end
    endtask

    task automatic send_pkt(input logic [63:0] tag, input int len);
        for (int i = 1; i <= len; i++) send_word(tag + 64'(i), (i == len));
        s_TVALID = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || m_TVALID) && t < 300) begin
            step();
            t++;
        end
        if (t == 300) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d words left expected 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        s_TVALID = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic chk_egress(input string nm, input logic [63:0] d, input logic l);
        chk({nm, "_valid"}, {63'd0, m_TVALID}, 64'd1);
        chk({nm, "_data"}, m_TDATA, d);
        chk({nm, "_last"}, {63'd0, m_TLAST}, {63'd0, l});
    endtask

    initial begin
        int base;
        int total;
        bit rnd_done;
        rst_n    = 1'b0;
        s_TDATA  = '0;
        s_TVALID = 1'b0;
        s_TLAST  = 1'b0;
        m_TREADY = 1'b0;
        #2;
        chk("reset_s_tready", {63'd0, s_TREADY}, 64'd0);
        chk("reset_m_tvalid", {63'd0, m_TVALID}, 64'd0);
        chk("reset_m_tdata", m_TDATA, 64'd0);
        do_reset();

        // 3-word packet, gapless egress one cycle after commit
        m_TREADY = 1'b1;
        send_pkt(64'hA000_0000_0000_0000, 3);
        chk("s1_valid_at_commit", {63'd0, m_TVALID}, 64'd0);
        step();
        chk_egress("s1_a1", 64'hA000_0000_0000_0001, 1'b0);
        step();
        chk_egress("s1_a2", 64'hA000_0000_0000_0002, 1'b0);
        step();
        chk_egress("s1_a3", 64'hA000_0000_0000_0003, 1'b1);
        step();
        chk("s1_idle", {63'd0, m_TVALID}, 64'd0);

        // exactly DEPTH words is committed, then the array is full
        do_reset();
        m_TREADY = 1'b0;
        send_pkt(64'hB000_0000_0000_0000, 16);
        chk("s2_full_ready", {63'd0, s_TREADY}, 64'd0);
        step();
        chk_egress("s2_head", 64'hB000_0000_0000_0001, 1'b0);
        chk("s2_no_drop", {48'd0, drop_count}, 64'd0);
        base = egress_cnt;
        m_TREADY = 1'b1;
        wait_drain();
        chk("s2_drained_words", 64'(egress_cnt - base), 64'd16);

        // 20-word packet is dropped whole
        do_reset();
        send_pkt(64'hC000_0000_0000_0000, 20);
        chk("s3_pulse", {63'd0, drop_pulse}, 64'd1);
        chk("s3_count", {48'd0, drop_count}, 64'd1);
        chk("s3_no_valid", {63'd0, m_TVALID}, 64'd0);
        step();
        chk("s3_pulse_end", {63'd0, drop_pulse}, 64'd0);

        // P, oversize Q, R -> egress P then R
        do_reset();
        base = egress_cnt;
        send_pkt(64'hD100_0000_0000_0000, 5);
        send_pkt(64'hD200_0000_0000_0000, 20);
        send_pkt(64'hD300_0000_0000_0000, 2);
        wait_drain();
        chk("s4_words", 64'(egress_cnt - base), 64'd7);
        chk("s4_count", {48'd0, drop_count}, 64'd1);

        // random stream with random egress back-pressure
        base     = egress_cnt;
        total    = 0;
        rnd_done = 0;
        fork
            begin
                for (int p = 0; p < 50; p++) begin
                    int len;
                    len = int'($urandom_range(1, 12));
                    for (int i = 1; i <= len; i++) begin
                        if ($urandom_range(0, 3) == 0) begin
                            s_TVALID = 1'b0;
                            step();
                        end
                        send_word({16'(p), 16'(i), 32'($urandom)}, (i == len));
                    end
                    s_TVALID = 1'b0;
                    total += len;
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    step();
                    m_TREADY = 1'($urandom_range(0, 1));
                end
            end
        join
        m_TREADY = 1'b1;
        wait_drain();
        chk("s5_words", 64'(egress_cnt - base), 64'(total));

        // reset mid-packet while egress is busy
        send_pkt(64'hE100_0000_0000_0000, 6);
        for (int i = 1; i <= 4; i++) send_word(64'hE200_0000_0000_0000 + 64'(i), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_s_tready", {63'd0, s_TREADY}, 64'd0);
        chk("s6_m_tvalid", {63'd0, m_TVALID}, 64'd0);
        chk("s6_m_tlast", {63'd0, m_TLAST}, 64'd0);
        chk("s6_m_tdata", m_TDATA, 64'd0);
        chk("s6_drop_pulse", {63'd0, drop_pulse}, 64'd0);
        chk("s6_drop_count", {48'd0, drop_count}, 64'd0);
        s_TVALID = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        send_pkt(64'hF000_0000_0000_0000, 2);
        chk("s6_valid_at_commit", {63'd0, m_TVALID}, 64'd0);
        step();
        chk_egress("s6_b1", 64'hF000_0000_0000_0001, 1'b0);
        step();
        chk_egress("s6_b2", 64'hF000_0000_0000_0002, 1'b1);
        step();
        chk("s6_idle", {63'd0, m_TVALID}, 64'd0);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
